// File: rtl/qupls_checkpoint_valid_ram_mp_pkg.sv
// Rename-stage sizing and index types shared by the checkpoint valid-bit store.
// Also holds small range-check helpers used on every indexed access.
package qupls_checkpoint_valid_ram_mp_pkg;

    localparam int NCHECK = 16;
    localparam int PREGS  = 512;

    typedef logic [$clog2(NCHECK)-1:0] checkpt_ndx_t;
    typedef logic [$clog2(PREGS)-1:0]  pregno_t;

    function automatic logic cp_in_range(input checkpt_ndx_t cp);
        return int'(cp) < NCHECK;
    endfunction

    function automatic logic preg_in_range(input pregno_t preg);
        return int'(preg) < PREGS;
    endfunction

endpackage

// File: rtl/qupls_wr_port_serialiser.sv
// Captures a core cycle's write ports on ph_sync and replays them over NPHASE
// fast cycles, presenting NWRPORTS/NPHASE lanes per phase.
module qupls_wr_port_serialiser
    import qupls_checkpoint_valid_ram_mp_pkg::*;
#(
    parameter int NWRPORTS = 10,
    parameter int NPHASE   = 5,
    parameter int NLANE    = NWRPORTS / NPHASE
)(
    input  logic                clk5x,
    input  logic                rst,
    input  logic                ph_sync,
    input  logic                ena,
    input  logic [NWRPORTS-1:0] wea,
    input  checkpt_ndx_t        cpa [NWRPORTS],
    input  pregno_t             prega [NWRPORTS],
    input  logic [NWRPORTS-1:0] dina,
    output logic                wr_busy,
    output logic [NLANE-1:0]    lane_we,
    output checkpt_ndx_t        lane_cp [NLANE],
    output pregno_t             lane_preg [NLANE],
    output logic [NLANE-1:0]    lane_din
);

    localparam int CW = $clog2(NPHASE + 1);
    localparam int PW = (NWRPORTS > 1) ? $clog2(NWRPORTS) : 1;
    localparam logic [CW-1:0] PH_IDLE = CW'(NPHASE);

    logic [NWRPORTS-1:0] wea_q, wea_d;
    logic [NWRPORTS-1:0] dina_q, dina_d;
    checkpt_ndx_t        cpa_q [NWRPORTS];
    checkpt_ndx_t        cpa_d [NWRPORTS];
    pregno_t             prega_q [NWRPORTS];
    pregno_t             prega_d [NWRPORTS];
    logic [CW-1:0]       cnt_q, cnt_d;

    // Lane j in phase c carries holding port j*NPHASE + c.
    function automatic logic [PW-1:0] port_of(input int lane, input logic [CW-1:0] ph);
        return PW'(lane * NPHASE + int'(ph));
    endfunction

    always_comb begin
        wea_d   = wea_q;
        dina_d  = dina_q;
        cpa_d   = cpa_q;
        prega_d = prega_q;
        cnt_d   = cnt_q;
        if (ph_sync) begin
            wea_d   = wea & {NWRPORTS{ena}};
            dina_d  = dina;
            cpa_d   = cpa;
            prega_d = prega;
            cnt_d   = '0;
        end else if (cnt_q < PH_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk5x) begin
        if (rst) begin
            wea_q  <= '0;
            dina_q <= '0;
            cnt_q  <= PH_IDLE;
            for (int i = 0; i < NWRPORTS; i++) begin
                cpa_q[i]   <= '0;
                prega_q[i] <= '0;
            end
        end else begin
            wea_q   <= wea_d;
            dina_q  <= dina_d;
            cnt_q   <= cnt_d;
            cpa_q   <= cpa_d;
            prega_q <= prega_d;
        end
    end

    assign wr_busy = (cnt_q < PH_IDLE);

    always_comb begin
        for (int j = 0; j < NLANE; j++) begin
            lane_we[j]   = 1'b0;
            lane_cp[j]   = '0;
            lane_preg[j] = '0;
            lane_din[j]  = 1'b0;
            if (wr_busy) begin
                lane_we[j]   = wea_q[port_of(j, cnt_q)];
                lane_cp[j]   = cpa_q[port_of(j, cnt_q)];
                lane_preg[j] = prega_q[port_of(j, cnt_q)];
                lane_din[j]  = dina_q[port_of(j, cnt_q)];
            end
        end
    end

    // A recapture while phases remain silently drops them.
    lost_phases_a: assert property (@(posedge clk5x) disable iff (rst) !(ph_sync && wr_busy));

endmodule

// File: rtl/qupls_checkpoint_valid_ram_mp.sv
// Per-checkpoint physical-register valid bits: serialised lane writes,
// new-checkpoint row copy with write merge, and registered multi-port reads.
module qupls_checkpoint_valid_ram_mp
    import qupls_checkpoint_valid_ram_mp_pkg::*;
#(
    parameter int NWRPORTS  = 10,
    parameter int NRDPORTS  = 24,
    parameter int NPHASE    = 5,
    parameter int RD_BYPASS = 1
)(
    input  logic                clk5x,
    input  logic                rst,
    input  logic                ph_sync,
    input  logic                ena,
    input  logic [NWRPORTS-1:0] wea,
    input  checkpt_ndx_t        cpa [NWRPORTS],
    input  pregno_t             prega [NWRPORTS],
    input  logic [NWRPORTS-1:0] dina,
    output logic                wr_busy,
    input  checkpt_ndx_t        cpb [NRDPORTS],
    input  pregno_t             pregb [NRDPORTS],
    output logic [NRDPORTS-1:0] doutb,
    input  logic                ncp_req,
    input  checkpt_ndx_t        ncp_ra,
    input  checkpt_ndx_t        ncp_wa,
    output logic                ncp_ack
);

    localparam int NLANE = NWRPORTS / NPHASE;

    if ((NWRPORTS % NPHASE) != 0) begin : g_bad_ratio
        $fatal(1, "NWRPORTS must be a multiple of NPHASE");
    end

    logic [NLANE-1:0] lane_we;
    logic [NLANE-1:0] lane_din;
    checkpt_ndx_t     lane_cp [NLANE];
    pregno_t          lane_preg [NLANE];

    qupls_wr_port_serialiser #(
        .NWRPORTS (NWRPORTS),
        .NPHASE   (NPHASE),
        .NLANE    (NLANE)
    ) u_serialiser (
        .clk5x     (clk5x),
        .rst       (rst),
        .ph_sync   (ph_sync),
        .ena       (ena),
        .wea       (wea),
        .cpa       (cpa),
        .prega     (prega),
        .dina      (dina),
        .wr_busy   (wr_busy),
        .lane_we   (lane_we),
        .lane_cp   (lane_cp),
        .lane_preg (lane_preg),
        .lane_din  (lane_din)
    );

    (* ram_style = "distributed" *) logic [PREGS-1:0] mem_q [NCHECK];
    logic [PREGS-1:0]    mem_d [NCHECK];
    logic                ncp_ack_q, ncp_ack_d;
    logic [NRDPORTS-1:0] doutb_q, doutb_d;
    logic                copy_go;

    // The ack cycle blocks a second copy from a still-held request.
    assign copy_go   = ncp_req & ~ncp_ack_q;
    assign ncp_ack_d = copy_go;

    // Lanes apply in ascending order so the highest lane wins a conflict; the
    // copy then reads the merged source row and overrides lane writes to ncp_wa.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NLANE; j++) begin
            if (lane_we[j] && cp_in_range(lane_cp[j]) && preg_in_range(lane_preg[j])) begin
                mem_d[lane_cp[j]][lane_preg[j]] = lane_din[j];
            end
        end
        if (copy_go && cp_in_range(ncp_ra) && cp_in_range(ncp_wa)) begin
            mem_d[ncp_wa] = mem_d[ncp_ra];
        end
    end

    // Physical register 0 is hard-wired valid; reads use pre-write/pre-copy rows.
    always_comb begin
        for (int r = 0; r < NRDPORTS; r++) begin
            doutb_d[r] = 1'b0;
            if (cp_in_range(cpb[r]) && preg_in_range(pregb[r])) begin
                doutb_d[r] = mem_q[cpb[r]][pregb[r]];
            end
            if (RD_BYPASS != 0) begin
                for (int j = 0; j < NLANE; j++) begin
                    if (lane_we[j] && lane_cp[j] == cpb[r] && lane_preg[j] == pregb[r]) begin
                        doutb_d[r] = lane_din[j];
                    end
                end
            end
            if (pregb[r] == '0) begin
                doutb_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk5x) begin
        if (rst) begin
            for (int i = 0; i < NCHECK; i++) begin
                mem_q[i] <= '1;
            end
            ncp_ack_q <= 1'b0;
            doutb_q   <= '0;
        end else begin
            mem_q     <= mem_d;
            ncp_ack_q <= ncp_ack_d;
            doutb_q   <= doutb_d;
        end
    end

    assign doutb   = doutb_q;
    assign ncp_ack = ncp_ack_q;

    ncp_range_a: assert property (@(posedge clk5x) disable iff (rst)
        !ncp_req || (cp_in_range(ncp_ra) && cp_in_range(ncp_wa)));

    for (genvar j = 0; j < NLANE; j++) begin : g_lane_chk
        lane_range_a: assert property (@(posedge clk5x) disable iff (rst)
            !lane_we[j] || (cp_in_range(lane_cp[j]) && preg_in_range(lane_preg[j])));
    end

endmodule

// File: tb/tb_qupls_checkpoint_valid_ram_mp.sv
// Directed scenarios plus randomized traffic against a behavioural model of
// the checkpoint valid-bit store.
module tb_qupls_checkpoint_valid_ram_mp;
    import qupls_checkpoint_valid_ram_mp_pkg::*;

    localparam int NWRPORTS  = 10;
    localparam int NRDPORTS  = 24;
    localparam int NPHASE    = 5;
    localparam int RD_BYPASS = 1;

    logic                clk5x = 1'b0;
    logic                rst;
    logic                ph_sync;
    logic                ena;
    logic [NWRPORTS-1:0] wea;
    checkpt_ndx_t        cpa [NWRPORTS];
    pregno_t             prega [NWRPORTS];
    logic [NWRPORTS-1:0] dina;
    logic                wr_busy;
    checkpt_ndx_t        cpb [NRDPORTS];
    pregno_t             pregb [NRDPORTS];
    logic [NRDPORTS-1:0] doutb;
    logic                ncp_req;
    checkpt_ndx_t        ncp_ra;
    checkpt_ndx_t        ncp_wa;
    logic                ncp_ack;

    int checks = 0;
    int errors = 0;

    qupls_checkpoint_valid_ram_mp #(
        .NWRPORTS  (NWRPORTS),
        .NRDPORTS  (NRDPORTS),
        .NPHASE    (NPHASE),
        .RD_BYPASS (RD_BYPASS)
    ) dut (
        .clk5x   (clk5x),
        .rst     (rst),
        .ph_sync (ph_sync),
        .ena     (ena),
        .wea     (wea),
        .cpa     (cpa),
        .prega   (prega),
        .dina    (dina),
        .wr_busy (wr_busy),
        .cpb     (cpb),
        .pregb   (pregb),
        .doutb   (doutb),
        .ncp_req (ncp_req),
        .ncp_ra  (ncp_ra),
        .ncp_wa  (ncp_wa),
        .ncp_ack (ncp_ack)
    );

    always #5 clk5x = ~clk5x;

    // Reference model: a bit matrix per checkpoint, plus the captured port set
    // and the number of fast cycles since capture.
    bit                  mdl_mem [NCHECK][PREGS];
    bit                  h_we [NWRPORTS];
    int                  h_cp [NWRPORTS];
    int                  h_preg [NWRPORTS];
    bit                  h_din [NWRPORTS];
    int                  since = NPHASE;
    bit                  mdl_ack = 1'b0;
    bit                  exp_busy = 1'b0;
    logic [NRDPORTS-1:0] exp_dout = '0;

    always @(posedge clk5x) begin : ref_model
        int wcp[$];
        int wpr[$];
        bit wdn[$];
        bit row [PREGS];
        bit go;
        bit v;
        wcp.delete();
        wpr.delete();
        wdn.delete();
        if (rst) begin
            for (int c = 0; c < NCHECK; c++)
                for (int b = 0; b < PREGS; b++)
                    mdl_mem[c][b] = 1'b1;
            for (int p = 0; p < NWRPORTS; p++) begin
                h_we[p] = 0; h_cp[p] = 0; h_preg[p] = 0; h_din[p] = 0;
            end
            since    = NPHASE;
            mdl_ack  = 1'b0;
            exp_busy = 1'b0;
            exp_dout = '0;
        end else begin
            // Port p is replayed at phase p % NPHASE; ascending p is ascending lane.
            if (since < NPHASE) begin
                for (int p = 0; p < NWRPORTS; p++) begin
                    if (p % NPHASE == since && h_we[p]) begin
                        wcp.push_back(h_cp[p]);
                        wpr.push_back(h_preg[p]);
                        wdn.push_back(h_din[p]);
                    end
                end
            end
            for (int r = 0; r < NRDPORTS; r++) begin
                v = mdl_mem[int'(cpb[r])][int'(pregb[r])];
                if (RD_BYPASS != 0) begin
                    for (int k = 0; k < wcp.size(); k++)
                        if (wcp[k] == int'(cpb[r]) && wpr[k] == int'(pregb[r])) v = wdn[k];
                end
                if (pregb[r] == '0) v = 1'b1;
                exp_dout[r] = v;
            end
            go = ncp_req && !mdl_ack;
            for (int k = 0; k < wcp.size(); k++) mdl_mem[wcp[k]][wpr[k]] = wdn[k];
            if (go) begin
                for (int b = 0; b < PREGS; b++) row[b] = mdl_mem[int'(ncp_ra)][b];
                for (int b = 0; b < PREGS; b++) mdl_mem[int'(ncp_wa)][b] = row[b];
            end
            mdl_ack = go;
            if (ph_sync) begin
                for (int p = 0; p < NWRPORTS; p++) begin
                    h_we[p]   = wea[p] && ena;
                    h_cp[p]   = int'(cpa[p]);
                    h_preg[p] = int'(prega[p]);
                    h_din[p]  = dina[p];
                end
                since = 0;
            end else if (since < NPHASE) begin
                since++;
            end
            exp_busy = (since < NPHASE);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    task automatic compareModel();
        checkOutput("wr_busy", 64'(wr_busy), 64'(exp_busy));
        checkOutput("ncp_ack", 64'(ncp_ack), 64'(mdl_ack));
        checkOutput("doutb", 64'(doutb), 64'(exp_dout));
    endtask

    task automatic step();
        @(posedge clk5x);
        @(negedge clk5x);
        compareModel();
    endtask

    task automatic clearWrites();
        wea  = '0;
        dina = '0;
        for (int p = 0; p < NWRPORTS; p++) begin
            cpa[p]   = '0;
            prega[p] = '0;
        end
    endtask

    task automatic setRead(input int r, input int cp, input int preg);
        cpb[r]   = checkpt_ndx_t'(cp);
        pregb[r] = pregno_t'(preg);
    endtask

    task automatic setWrite(input int p, input int cp, input int preg, input bit din);
        wea[p]   = 1'b1;
        cpa[p]   = checkpt_ndx_t'(cp);
        prega[p] = pregno_t'(preg);
        dina[p]  = din;
    endtask

    // Small index sets keep reads and writes colliding often.
    function automatic int rndCp();
        return ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NCHECK-1));
    endfunction

    function automatic int rndPreg();
        return ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, PREGS-1));
    endfunction

    bit drop_next = 1'b0;

    task automatic applyStimulus();
        rst     = ($urandom_range(0, 299) == 0);
        ph_sync = 1'b0;
        clearWrites();
        if (!exp_busy && $urandom_range(0, 2) == 0) begin
            ph_sync = 1'b1;
            ena     = ($urandom_range(0, 7) != 0);
            for (int p = 0; p < NWRPORTS; p++) begin
                wea[p]   = 1'($urandom_range(0, 1));
                cpa[p]   = checkpt_ndx_t'(rndCp());
                prega[p] = pregno_t'(rndPreg());
                dina[p]  = 1'($urandom_range(0, 1));
            end
        end
        for (int r = 0; r < NRDPORTS; r++) setRead(r, rndCp(), rndPreg());
        if (ncp_req) begin
            if (drop_next) begin
                ncp_req   = 1'b0;
                drop_next = 1'b0;
            end else if (mdl_ack) begin
                if ($urandom_range(0, 1) == 0) ncp_req = 1'b0;
                else drop_next = 1'b1;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            ncp_req = 1'b1;
            ncp_ra  = checkpt_ndx_t'(rndCp());
            ncp_wa  = checkpt_ndx_t'(rndCp());
        end
        if (rst) begin
            ncp_req   = 1'b0;
            drop_next = 1'b0;
        end
    endtask

    int busy_cycles;
    int acks;

    initial begin
        rst = 1'b1; ph_sync = 1'b0; ena = 1'b0;
        ncp_req = 1'b0; ncp_ra = '0; ncp_wa = '0;
        clearWrites();
        for (int r = 0; r < NRDPORTS; r++) setRead(r, r % NCHECK, 1 + r * 17);
        repeat (3) step();
        checkOutput("rst_busy", 64'(wr_busy), 64'd0);
        checkOutput("rst_ack", 64'(ncp_ack), 64'd0);
        checkOutput("rst_doutb", 64'(doutb), 64'd0);
        rst = 1'b0;
        step();
        checkOutput("rst_all_ones", 64'(doutb), 64'({NRDPORTS{1'b1}}));

        // Single write on port 7 (lane 1, phase 2) with a copy 3 -> 5 in that phase.
        ena = 1'b1; ph_sync = 1'b1;
        setWrite(7, 3, 40, 1'b0);
        setRead(0, 3, 40); setRead(1, 2, 40); setRead(2, 5, 40);
        busy_cycles = 0; acks = 0;
        step(); ph_sync = 1'b0; clearWrites(); busy_cycles += int'(wr_busy);
        step(); busy_cycles += int'(wr_busy);
        step(); busy_cycles += int'(wr_busy);
        checkOutput("p7_before_phase2", 64'(doutb[0]), 64'd1);
        ncp_req = 1'b1; ncp_ra = 4'd3; ncp_wa = 4'd5;
        step(); busy_cycles += int'(wr_busy); acks += int'(ncp_ack);
        checkOutput("p7_bypass_cp3", 64'(doutb[0]), 64'd0);
        checkOutput("p7_cp2_untouched", 64'(doutb[1]), 64'd1);
        checkOutput("copy_cycle_cp5_old", 64'(doutb[2]), 64'd1);
        checkOutput("ack_pulse", 64'(ncp_ack), 64'd1);
        step(); busy_cycles += int'(wr_busy); acks += int'(ncp_ack);
        ncp_req = 1'b0;
        checkOutput("cp3_p40_stored", 64'(doutb[0]), 64'd0);
        checkOutput("cp5_p40_copied", 64'(doutb[2]), 64'd0);
        repeat (4) begin
            step(); busy_cycles += int'(wr_busy); acks += int'(ncp_ack);
        end
        checkOutput("busy_cycles", 64'(busy_cycles), 64'd5);
        checkOutput("single_ack", 64'(acks), 64'd1);

        // Clear cp1/p9, then ports 2 and 7 collide on it in phase 2.
        ph_sync = 1'b1;
        setWrite(0, 1, 9, 1'b0);
        step(); ph_sync = 1'b0; clearWrites();
        repeat (5) step();
        setRead(0, 1, 9);
        step();
        checkOutput("cp1_p9_cleared", 64'(doutb[0]), 64'd0);
        ph_sync = 1'b1;
        setWrite(2, 1, 9, 1'b0);
        setWrite(7, 1, 9, 1'b1);
        step(); ph_sync = 1'b0; clearWrites();
        step(); step();
        checkOutput("conflict_pre", 64'(doutb[0]), 64'd0);
        step();
        checkOutput("conflict_bypass", 64'(doutb[0]), 64'd1);
        step();
        checkOutput("conflict_stored", 64'(doutb[0]), 64'd1);
        repeat (3) step();

        // Writing 0 to preg 0 never makes it read invalid.
        ph_sync = 1'b1;
        setWrite(0, 4, 0, 1'b0);
        step(); ph_sync = 1'b0; clearWrites();
        repeat (6) step();
        setRead(0, 4, 0);
        step();
        checkOutput("preg0_reads_one", 64'(doutb[0]), 64'd1);

        // Reset in phase 2 of a full burst discards the remaining phases.
        ph_sync = 1'b1;
        for (int p = 0; p < NWRPORTS; p++) begin
            setWrite(p, 6, 100 + p, 1'b0);
            setRead(p, 6, 100 + p);
        end
        step(); ph_sync = 1'b0; clearWrites();
        step(); step();
        rst = 1'b1;
        step();
        checkOutput("rst_mid_busy", 64'(wr_busy), 64'd0);
        rst = 1'b0;
        step();
        checkOutput("rst_mid_ones", 64'(doutb[NWRPORTS-1:0]), 64'({NWRPORTS{1'b1}}));
        repeat (3) step();
        checkOutput("rst_mid_no_late", 64'(doutb[NWRPORTS-1:0]), 64'({NWRPORTS{1'b1}}));
        checkOutput("rst_mid_idle", 64'(wr_busy), 64'd0);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
